// File: rtl/input_pkg.sv
// Shared constants, state type and event-word packing for input_event_latch.
package input_pkg;

  localparam int BTN_W    = 12;
  localparam int NUM_IDX  = 2 * BTN_W;
  localparam int RSVD_IDX1 = BTN_W - 1;
  localparam int RSVD_IDX2 = NUM_IDX - 1;

  localparam logic [7:0] ADDR_HELD1    = 8'h00;
  localparam logic [7:0] ADDR_HELD2    = 8'h01;
  localparam logic [7:0] ADDR_PRESSED1 = 8'h02;
  localparam logic [7:0] ADDR_PRESSED2 = 8'h03;
  localparam logic [7:0] ADDR_EVENT    = 8'h04;
  localparam logic [7:0] ADDR_STATUS   = 8'h05;
  localparam logic [7:0] ADDR_CTRL     = 8'h06;

  localparam int EV_MARK_BIT  = 15;
  localparam int EV_CTRL_BIT  = 8;
  localparam int EV_PRESS_BIT = 7;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  function automatic logic [15:0] make_event(logic ctrl, logic press, logic [3:0] bit_idx);
    logic [15:0] w;
    w               = '0;
    w[EV_MARK_BIT]  = 1'b1;
    w[EV_CTRL_BIT]  = ctrl;
    w[EV_PRESS_BIT] = press;
    w[3:0]          = bit_idx;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_event_latch.sv
// Turns controller poll samples into press/release events, per-frame snapshots
// and a CPU register port with interrupt.
module input_event_latch #(
  parameter int DEPTH = 8,
  parameter int BTN_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] buttons1,
  input  logic [BTN_W-1:0] buttons2,
  input  logic             valid,
  input  logic             vblank_start,
  input  logic [7:0]       reg_addr,
  input  logic             reg_re,
  input  logic             reg_we,
  input  logic [15:0]      reg_wdata,
  output logic [15:0]      reg_rdata,
  output logic             irq
);

  import input_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = 2 * BTN_W;

  scan_state_t     state;
  logic [4:0]      idx;
  logic [NW-1:0]   diff;
  logic [NW-1:0]   prev;
  logic [NW-1:0]   acc;
  logic [NW-1:0]   acc_next;
  logic [NW-1:0]   press_vec;
  logic [BTN_W-1:0] held1, held2, pressed1, pressed2;
  logic            irq_en, ovf, missed;

  logic            push, ctrl, press, pop_req, pop_eff, drop;
  logic [3:0]      bit_idx;
  logic [15:0]     event_word;
  logic [15:0]     fifo_head;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            wdata_unused;

  assign wdata_unused = ^reg_wdata[15:2];

  // prev already holds the new sample while scanning, so its bit gives the direction.
  always_comb begin
    ctrl       = (idx >= 5'(BTN_W));
    bit_idx    = 4'(ctrl ? idx - 5'(BTN_W) : idx);
    press      = prev[idx];
    push       = (state == SCAN) && diff[idx] &&
                 (idx != 5'(RSVD_IDX1)) && (idx != 5'(RSVD_IDX2));
    event_word = make_event(ctrl, press, bit_idx);
    press_vec  = (push && press) ? (NW'(1) << idx) : '0;
    acc_next   = acc | press_vec;
    pop_req    = reg_re && (reg_addr == ADDR_EVENT);
    pop_eff    = pop_req && !empty;
    drop       = push && full && !pop_eff;
  end

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (event_word),
    .pop       (pop_req),
    .head      (fifo_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      diff  <= '0;
      prev  <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          diff  <= {buttons2, buttons1} ^ prev;
          prev  <= {buttons2, buttons1};
          idx   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (idx == 5'(NUM_IDX - 1)) state <= IDLE;
          else                        idx   <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      held1    <= '0;
      held2    <= '0;
      pressed1 <= '0;
      pressed2 <= '0;
    end else if (vblank_start) begin
      held1    <= prev[BTN_W-1:0];
      held2    <= prev[NW-1:BTN_W];
      pressed1 <= acc_next[BTN_W-1:0];
      pressed2 <= acc_next[NW-1:BTN_W];
      acc      <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  // Sticky bits: a set in the same cycle as a write-1 clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf    <= 1'b0;
      missed <= 1'b0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ovf    <= (ovf && !(reg_we && reg_addr == ADDR_STATUS && reg_wdata[0])) || drop;
      missed <= (missed && !(reg_we && reg_addr == ADDR_STATUS && reg_wdata[1])) ||
                (valid && state == SCAN);
      if (reg_we && reg_addr == ADDR_CTRL) irq_en <= reg_wdata[0];
      irq    <= irq_en && (count != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_rdata <= '0;
    end else if (reg_re) begin
      case (reg_addr)
        ADDR_HELD1:    reg_rdata <= 16'(held1);
        ADDR_HELD2:    reg_rdata <= 16'(held2);
        ADDR_PRESSED1: reg_rdata <= 16'(pressed1);
        ADDR_PRESSED2: reg_rdata <= 16'(pressed2);
        ADDR_EVENT:    reg_rdata <= empty ? 16'h0000 : fifo_head;
        ADDR_STATUS:   reg_rdata <= {8'(count), 6'b0, missed, ovf};
        ADDR_CTRL:     reg_rdata <= {15'b0, irq_en};
        default:       reg_rdata <= 16'h0000;
      endcase
    end
  end

endmodule

// File: doc/input_event_latch.md
# input_event_latch

Downstream consumer of the DB9 input controller. Takes the 12-bit per-controller button vectors and their `valid` poll strobe, and detects press/release edges. Edges are queued as events in a small FIFO and accumulated into per-frame snapshots latched at vblank. Exposes the result to the CPU through a registered read/write port with an optional interrupt.

## Interface
- `DEPTH`, 8: event FIFO entries; power of two, 2..128.
- `BTN_W`, 12: buttons per controller; fixed at 12, where bit 11 is reserved and never produces events.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `buttons1` in 12: controller 1 state, 1 = pressed.
- `buttons2` in 12: controller 2 state.
- `valid` in 1: 1-cycle strobe; `buttons1`/`buttons2` are stable when it is high.
- `vblank_start` in 1: 1-cycle pulse at the start of each frame.
- `reg_addr` in 8: register select.
- `reg_re` in 1: read strobe.
- `reg_we` in 1: write strobe.
- `reg_wdata` in 16: write data.
- `reg_rdata` out 16: registered read data.
- `irq` out 1: registered, level-high interrupt.

## Operation
- Shadow state: `prev1`, `prev2` (last accepted sample).
- Accumulators: `acc1`, `acc2` (presses seen since the last vblank).
- Latched state:
  - `held1`, `held2`, `pressed1`, `pressed2`
  - `irq_en`
  - sticky `ovf` and `missed` bits.
- FSM `IDLE` / `SCAN`:
  - In IDLE, `valid` captures `diff = {buttons2,buttons1} ^ {prev2,prev1}` (24 bits). It also loads `prev` from the inputs, resets index to 0 and enters SCAN.
  - In SCAN, one index is examined per cycle. If `diff[i]` is set, one event is pushed. After index 23 the FSM returns to IDLE.
  - `valid` arriving during SCAN is dropped and sets `missed`. `prev` is not updated, so the next accepted sample reports the net change.
- Event word:
  - `[15]` = 1 (entry-present marker).
  - `[8]` = controller (0 = ctrl1, 1 = ctrl2).
  - `[7]` = 1 for press, 0 for release.
  - `[3:0]` = bit index 0..11.
  - All other bits 0.
- Indices 11 and 23 are never pushed.
- Every press event also ORs its bit into `acc1`/`acc2`.
- On `vblank_start`:
  - `held` <= `prev`.
  - `pressed` <= `acc` | any press being pushed in the same cycle.
  - `acc` <= 0.
- FIFO push rules:
  - A push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `ovf` is set.
  - Simultaneous push and pop leaves count unchanged.
- Registers (all reads are registered; a read of an unmapped address returns 0):
  - 0x00 R: `{4'b0, held1}`
  - 0x01 R: `{4'b0, held2}`
  - 0x02 R: `{4'b0, pressed1}`
  - 0x03 R: `{4'b0, pressed2}`
  - 0x04 R: pops the FIFO head. An empty FIFO returns 0x0000 and nothing changes.
  - 0x05 R: `{count[7:0], 6'b0, missed, ovf}`. W: write 1 to bit 0/1 to clear the matching sticky bit. If a clear and a set happen in the same cycle, the set wins.
  - 0x06 R/W: bit 0 = `irq_en`.
- `irq` <= `irq_en` & (count != 0).

## Timing
- Reset: all outputs 0; `prev`, `acc`, `held`, `pressed`, count, pointers, sticky bits and `irq_en` are all 0; FSM goes to IDLE.
  - Because `prev` resets to 0, buttons already held at the first sample produce press events.
- Reset asserted mid-SCAN aborts the scan. The partial FIFO contents are discarded.
- `valid` in IDLE at cycle N: index i is examined at N+1+i and is reflected in count at N+2+i. IDLE is re-entered at N+25, and a `valid` at N+25 is accepted.
- Read latency: `reg_rdata` is valid the cycle after `reg_re`. A pop takes effect in that same edge.
- `irq` lags count by one cycle.
- Read and write in the same cycle to different addresses: both are performed.

## Structure
- Package `input_pkg`:
  - register address constants 0x00–0x06
  - event field positions
  - `BTN_W`
  - number of scan indices (24)
- Sub-module `sync_fifo`: parameterised width/depth, with push/pop/count/full/empty. The FIFO is the only natural split; the FSM, accumulators and register decode stay in the top.

## Test plan
- After reset, `valid` with `buttons1`=0x001, `buttons2`=0 -> one event 0x8080; count=1; `irq`=0 until 0x06 is written to 1, then `irq`=1 one cycle later.
- `buttons1` 0x001→0x010 -> two events, in order: 0x8000 (release bit 0), then 0x8084 (press bit 4); a read of 0x04 with an empty FIFO afterwards returns 0x0000.
- `buttons2` bit 10 pressed, then `vblank_start` -> 0x03 reads 0x0400 and 0x01 reads 0x0400; after a second vblank with no new press, 0x03 reads 0x0000.
- With DEPTH=8, a sample with 11 changed bits (0x7FF) -> 8 events queued; 0x05 reads 0x0801 (count 8, `ovf` set); writing 0x0001 to 0x05 clears `ovf`.
- `valid` again 5 cycles into a SCAN -> `missed` set and the second sample ignored; the next accepted sample yields the net diff versus `prev`.
- Reset asserted mid-SCAN -> count 0, `reg_rdata` 0, FSM in IDLE; the following `valid` is processed normally.
